// File: rtl/rs_pkg.sv
// Shared reservation-station types and default widths, used by the RS and the load/store buffer.
package rs_pkg;

  localparam int RS_DEPTH  = 4;
  localparam int RS_DATA_W = 32;
  localparam int RS_OP_W   = 6;
  localparam int RS_TAG_W  = 4;
  localparam int RS_CDB_N  = 2;

  // ROB tag 0 marks an operand whose value is already present.
  localparam logic [RS_TAG_W-1:0] TAG_INVALID = '0;

  typedef struct packed {
    logic                 valid;
    logic [RS_OP_W-1:0]   op;
    logic [RS_TAG_W-1:0]  tag1;
    logic [RS_TAG_W-1:0]  tag2;
    logic [RS_DATA_W-1:0] val1;
    logic [RS_DATA_W-1:0] val2;
    logic [RS_TAG_W-1:0]  target;
  } rs_entry_t;

endpackage

// File: rtl/reserv_station_wakeup_if.sv
// Dispatch, CDB snoop and issue signals of one reservation station.
interface reserv_station_wakeup_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 4,
  parameter int CDB_N  = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                    flush;
  logic                    push_valid;
  logic                    push_ready;
  logic [OP_W-1:0]         push_op;
  logic [2*TAG_W-1:0]      push_tag;
  logic [2*DATA_W-1:0]     push_val;
  logic [TAG_W-1:0]        push_target;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*DATA_W-1:0] cdb_val;
  logic                    issue_valid;
  logic                    issue_ready;
  logic [OP_W-1:0]         issue_op;
  logic [2*DATA_W-1:0]     issue_val;
  logic [TAG_W-1:0]        issue_target;
  logic [OCC_W-1:0]        occupancy;

  modport master (
    output flush, push_valid, push_op, push_tag, push_val, push_target,
    output cdb_valid, cdb_tag, cdb_val, issue_ready,
    input  push_ready, issue_valid, issue_op, issue_val, issue_target, occupancy
  );

  modport slave (
    input  flush, push_valid, push_op, push_tag, push_val, push_target,
    input  cdb_valid, cdb_tag, cdb_val, issue_ready,
    output push_ready, issue_valid, issue_op, issue_val, issue_target, occupancy
  );

endinterface

// File: rtl/rs_age_select.sv
// Age matrix over DEPTH slots and oldest-ready picker; row i bit j set means slot i is older than slot j.
module rs_age_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] dealloc,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic             any
);

  logic [DEPTH-1:0] age [DEPTH];
  logic [DEPTH-1:0] older_ready;

  // A new entry is younger than every slot; a leaving slot drops out of all relations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[j] && (i != j)) age[i][j] <= 1'b1;
          if (alloc[i])             age[i][j] <= 1'b0;
          if (dealloc[i] || dealloc[j]) age[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    older_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_ready[i] = older_ready[i] | (ready[j] & age[j][i]);
      end
    end
  end

  assign grant = ready & ~older_ready;
  assign any   = |ready;

endmodule

// File: rtl/reserv_station_wakeup.sv
// Reservation station: holds dispatched ops, wakes operands from the CDB by ROB tag, issues oldest ready.
module reserv_station_wakeup import rs_pkg::*; #(
  parameter int DEPTH  = RS_DEPTH,
  parameter int DATA_W = RS_DATA_W,
  parameter int OP_W   = RS_OP_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int CDB_N  = RS_CDB_N
) (
  input logic                    clk,
  input logic                    rst,
  reserv_station_wakeup_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_INVALID);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [TAG_W-1:0]  target;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] val;
  } snoop_t;

  entry_t            ent [DEPTH];
  logic [OCC_W-1:0]  occ;
  logic              issue_valid_r;
  logic [OP_W-1:0]   issue_op_r;
  logic [DATA_W-1:0] issue_val1_r;
  logic [DATA_W-1:0] issue_val2_r;
  logic [TAG_W-1:0]  issue_target_r;

  logic              push_ready_w;
  logic              push_fire;
  logic              free_found;
  logic [DEPTH-1:0]  alloc;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  grant;
  logic [DEPTH-1:0]  dealloc;
  logic              any_ready;
  logic              issue_load;
  entry_t            sel;
  entry_t            push_ent;
  snoop_t            push_s1;
  snoop_t            push_s2;
  snoop_t            wake1 [DEPTH];
  snoop_t            wake2 [DEPTH];

  // Lowest CDB port wins when several broadcast the same tag; tag 0 is never looked up.
  function automatic snoop_t cdb_lookup(
    input logic [TAG_W-1:0]        tag,
    input logic [CDB_N-1:0]        vld,
    input logic [CDB_N*TAG_W-1:0]  tags,
    input logic [CDB_N*DATA_W-1:0] vals
  );
    snoop_t r;
    r = '0;
    if (tag != TAG_NONE) begin
      for (int p = CDB_N - 1; p >= 0; p--) begin
        if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
          r.hit = 1'b1;
          r.val = vals[p*DATA_W +: DATA_W];
        end
      end
    end
    return r;
  endfunction

  assign push_ready_w = (occ < OCC_W'(DEPTH));
  assign push_fire    = bus.push_valid & push_ready_w;

  always_comb begin
    free_found = 1'b0;
    alloc      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent[i].valid && !free_found) begin
        free_found = 1'b1;
        alloc[i]   = push_fire;
      end
    end
  end

  always_comb begin
    push_s1         = cdb_lookup(bus.push_tag[TAG_W-1:0], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    push_s2         = cdb_lookup(bus.push_tag[2*TAG_W-1:TAG_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    push_ent.valid  = 1'b1;
    push_ent.op     = bus.push_op;
    push_ent.tag1   = push_s1.hit ? TAG_NONE : bus.push_tag[TAG_W-1:0];
    push_ent.tag2   = push_s2.hit ? TAG_NONE : bus.push_tag[2*TAG_W-1:TAG_W];
    push_ent.val1   = push_s1.hit ? push_s1.val : bus.push_val[DATA_W-1:0];
    push_ent.val2   = push_s2.hit ? push_s2.val : bus.push_val[2*DATA_W-1:DATA_W];
    push_ent.target = bus.push_target;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = cdb_lookup(ent[i].tag1, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      wake2[i] = cdb_lookup(ent[i].tag2, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      ready[i] = ent[i].valid && (ent[i].tag1 == TAG_NONE) && (ent[i].tag2 == TAG_NONE);
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .alloc   (alloc),
    .dealloc (dealloc),
    .ready   (ready),
    .grant   (grant),
    .any     (any_ready)
  );

  assign issue_load = (!issue_valid_r || bus.issue_ready) && any_ready;
  assign dealloc    = issue_load ? grant : '0;

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = ent[i];
    end
  end

  // Flush outranks push, wakeup and issue; the issue register holds while the unit stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      occ            <= '0;
      issue_valid_r  <= 1'b0;
      issue_op_r     <= '0;
      issue_val1_r   <= '0;
      issue_val2_r   <= '0;
      issue_target_r <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      occ           <= '0;
      issue_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].valid && wake1[i].hit) begin
          ent[i].tag1 <= TAG_NONE;
          ent[i].val1 <= wake1[i].val;
        end
        if (ent[i].valid && wake2[i].hit) begin
          ent[i].tag2 <= TAG_NONE;
          ent[i].val2 <= wake2[i].val;
        end
        if (dealloc[i]) ent[i].valid <= 1'b0;
        if (alloc[i])   ent[i] <= push_ent;
      end
      if (issue_load) begin
        issue_valid_r  <= 1'b1;
        issue_op_r     <= sel.op;
        issue_val1_r   <= sel.val1;
        issue_val2_r   <= sel.val2;
        issue_target_r <= sel.target;
      end else if (bus.issue_ready) begin
        issue_valid_r <= 1'b0;
      end
      occ <= occ + {{(OCC_W-1){1'b0}}, push_fire} - {{(OCC_W-1){1'b0}}, issue_load};
    end
  end

  assign bus.push_ready   = push_ready_w;
  assign bus.issue_valid  = issue_valid_r;
  assign bus.issue_op     = issue_op_r;
  assign bus.issue_val    = {issue_val2_r, issue_val1_r};
  assign bus.issue_target = issue_target_r;
  assign bus.occupancy    = occ;

endmodule

// File: tb/tb_reserv_station_wakeup.sv
// Directed bench for reserv_station_wakeup: expected issues queued at push time, monitor compares on handshake.
module tb_reserv_station_wakeup;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int TAG_W  = 4;
  localparam int CDB_N  = 2;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [2*DATA_W-1:0] val;
    logic [TAG_W-1:0]    target;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb [$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  reserv_station_wakeup_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .CDB_N(CDB_N)) bus();

  reserv_station_wakeup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .CDB_N(CDB_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int op, input int v1, input int v2, input int tgt);
    exp_t e;
    e.op     = OP_W'(op);
    e.val    = {DATA_W'(v2), DATA_W'(v1)};
    e.target = TAG_W'(tgt);
    return e;
  endfunction

  task automatic drive_push(input int op, input int t1, input int t2, input int v1, input int v2, input int tgt);
    bus.push_valid  = 1'b1;
    bus.push_op     = OP_W'(op);
    bus.push_tag    = {TAG_W'(t2), TAG_W'(t1)};
    bus.push_val    = {DATA_W'(v2), DATA_W'(v1)};
    bus.push_target = TAG_W'(tgt);
  endtask

  task automatic cdb_set(input int port, input int tag, input int val);
    bus.cdb_valid[port]                = 1'b1;
    bus.cdb_tag[port*TAG_W +: TAG_W]   = TAG_W'(tag);
    bus.cdb_val[port*DATA_W +: DATA_W] = DATA_W'(val);
  endtask

  task automatic cdb_clear;
    bus.cdb_valid = '0;
    bus.cdb_tag   = '0;
    bus.cdb_val   = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.issue_valid && bus.issue_ready) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_issue: got op 0x%0h target 0x%0h, required no issue", bus.issue_op, bus.issue_target);
        end else begin
          e = sb.pop_front();
          if ({bus.issue_op, bus.issue_val, bus.issue_target} === e) passed++;
          else $display("FAIL issue_data: got op=0x%0h val=0x%0h tgt=0x%0h, required op=0x%0h val=0x%0h tgt=0x%0h",
                        bus.issue_op, bus.issue_val, bus.issue_target, e.op, e.val, e.target);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stim
    bus.flush       = 1'b0;
    bus.push_valid  = 1'b0;
    bus.push_op     = '0;
    bus.push_tag    = '0;
    bus.push_val    = '0;
    bus.push_target = '0;
    bus.issue_ready = 1'b0;
    cdb_clear();
    #2 rst = 1'b0;
    repeat (3) tick();
    check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    check("rst_occupancy",   64'(bus.occupancy),   64'd0);
    check("rst_push_ready",  64'(bus.push_ready),  64'd1);
    check("rst_issue_op",    64'(bus.issue_op),    64'd0);
    check("rst_issue_val",   64'(bus.issue_val),   64'd0);
    rst = 1'b1;
    tick();

    // ready op issues two edges after being presented
    bus.issue_ready = 1'b1;
    drive_push(5, 0, 0, 3, 4, 7);
    sb.push_back(mk(5, 3, 4, 7));
    tick();
    bus.push_valid = 1'b0;
    check("ready_not_yet", 64'(bus.issue_valid), 64'd0);
    check("ready_occ_1",   64'(bus.occupancy),   64'd1);
    tick();
    check("ready_issue_valid", 64'(bus.issue_valid), 64'd1);
    check("ready_occ_0",       64'(bus.occupancy),   64'd0);
    tick();
    check("ready_drop", 64'(bus.issue_valid), 64'd0);

    // wakeup from CDB0 one cycle after push
    drive_push(6, 9, 0, 0, 'h22, 2);
    sb.push_back(mk(6, 'hAB, 'h22, 2));
    tick();
    bus.push_valid = 1'b0;
    cdb_set(0, 9, 'hAB);
    tick();
    cdb_clear();
    check("wake_not_yet", 64'(bus.issue_valid), 64'd0);
    tick();
    check("wake_issue", 64'(bus.issue_valid), 64'd1);
    tick();

    // capture on the push cycle; tag 0 broadcast must not disturb operand 1
    drive_push(7, 0, 5, 'h11, 0, 3);
    cdb_set(1, 5, 'hCD);
    cdb_set(0, 0, 'hEE);
    sb.push_back(mk(7, 'h11, 'hCD, 3));
    tick();
    bus.push_valid = 1'b0;
    cdb_clear();
    tick();
    check("capture_issue", 64'(bus.issue_valid), 64'd1);
    tick();

    // fill while stalled: one op parks in the issue register, four fill the entries
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_push(10 + k, 0, 0, 'h100 + k, 'h200 + k, k + 1);
      sb.push_back(mk(10 + k, 'h100 + k, 'h200 + k, k + 1));
      tick();
    end
    check("full_push_ready", 64'(bus.push_ready), 64'd0);
    check("full_occ",        64'(bus.occupancy),  64'd4);
    drive_push(15, 0, 0, 'hDEAD, 'hBEEF, 9);
    tick();
    tick();
    bus.push_valid = 1'b0;
    check("full_ignored_occ", 64'(bus.occupancy),   64'd4);
    check("full_stall_valid", 64'(bus.issue_valid), 64'd1);
    check("full_stall_op",    64'(bus.issue_op),    64'd10);
    bus.issue_ready = 1'b1;
    tick();
    check("drain_occ_3",      64'(bus.occupancy),  64'd3);
    check("drain_push_ready", 64'(bus.push_ready), 64'd1);
    repeat (5) tick();
    check("drain_occ_0",   64'(bus.occupancy),   64'd0);
    check("drain_idle",    64'(bus.issue_valid), 64'd0);

    // older blocked entry woken by both CDB ports: younger ready op issues first, port 0 wins
    sb.push_back(mk(21, 'h66, 'h77, 6));
    sb.push_back(mk(20, 1, 'h55, 5));
    drive_push(20, 3, 0, 0, 'h55, 5);
    tick();
    drive_push(21, 0, 0, 'h66, 'h77, 6);
    tick();
    bus.push_valid = 1'b0;
    cdb_set(0, 3, 1);
    cdb_set(1, 3, 2);
    tick();
    cdb_clear();
    check("age_first_valid", 64'(bus.issue_valid), 64'd1);
    check("age_occ",         64'(bus.occupancy),   64'd1);
    tick();
    tick();
    check("age_idle", 64'(bus.issue_valid), 64'd0);
    check("age_occ0", 64'(bus.occupancy),   64'd0);

    // flush with entries, a held issue and a simultaneous push
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_push(30 + k, 0, 0, k, k, k + 8);
      tick();
    end
    check("preflush_occ",   64'(bus.occupancy),   64'd3);
    check("preflush_valid", 64'(bus.issue_valid), 64'd1);
    drive_push(40, 0, 0, 1, 2, 3);
    bus.flush = 1'b1;
    tick();
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    check("flush_occ",        64'(bus.occupancy),   64'd0);
    check("flush_valid",      64'(bus.issue_valid), 64'd0);
    check("flush_push_ready", 64'(bus.push_ready),  64'd1);
    bus.issue_ready = 1'b1;
    repeat (3) tick();
    check("flush_no_ghost", 64'(bus.issue_valid), 64'd0);
    drive_push(41, 0, 0, 'h9, 'hA, 'hB);
    sb.push_back(mk(41, 'h9, 'hA, 'hB));
    tick();
    bus.push_valid = 1'b0;
    tick();
    check("postflush_issue", 64'(bus.issue_valid), 64'd1);
    tick();

    // asynchronous reset in the middle of traffic
    bus.issue_ready = 1'b0;
    drive_push(50, 0, 0, 1, 1, 1);
    tick();
    drive_push(51, 0, 0, 2, 2, 2);
    tick();
    bus.push_valid = 1'b0;
    check("prerst_valid", 64'(bus.issue_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_issue_valid", 64'(bus.issue_valid), 64'd0);
    check("midrst_occupancy",   64'(bus.occupancy),   64'd0);
    check("midrst_push_ready",  64'(bus.push_ready),  64'd1);
    check("midrst_issue_op",    64'(bus.issue_op),    64'd0);
    tick();
    rst = 1'b1;
    bus.issue_ready = 1'b1;
    repeat (3) tick();
    check("postrst_idle", 64'(bus.issue_valid), 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
